uart_tx_buffered: RTL and testbench

Parametrised, FIFO-buffered UART transmitter. Successor to the single-byte transmitter:
- runtime-selectable data length up to `DATA_BITS_MAX`;
- optional parity and 1 or 2 stop bits;
- a `FIFO_DEPTH`-entry transmit queue, so frames go out back-to-back with no idle gap.

It sits between the register/bus interface and the serial pin, and it is driven by the same `write_i` oneshot protocol.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_sync_fifo.sv | 59 +++++
 rtl/uart_tx_buffered.sv | 155 +++++++++++++++
 tb/tb_uart_tx_buffered.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types for the buffered UART transmitter: FSM state encoding and
// the per-frame configuration latched at the start of every frame.
package uart_pkg;

  localparam int unsigned DIVIDER_WIDTH_MAX = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  typedef struct packed {
    logic [3:0]                   data_bits;
    logic                         parity_en;
    logic                         parity_even;
    logic                         two_stop;
    logic [DIVIDER_WIDTH_MAX-1:0] divider;
  } frame_cfg_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with fall-through read data; push and pop may coincide at
// any fill level, and a push while full is accepted only alongside a pop.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// FIFO-buffered UART transmitter with runtime data length, optional parity
// and 1/2 stop bits; queued frames are sent back-to-back without idle gaps.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS_MAX = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned DIVIDER_WIDTH = 16
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               write_i,
  input  logic [DATA_BITS_MAX-1:0]           data_i,
  input  logic [$clog2(DATA_BITS_MAX+1)-1:0] data_bits_i,
  input  logic                               two_stop_bits_i,
  input  logic                               parity_bit_i,
  input  logic                               parity_even_i,
  input  logic [DIVIDER_WIDTH-1:0]           clock_divider_i,
  output logic                               serial_o,
  output logic                               busy_o,
  output logic                               full_o,
  output logic                               empty_o,
  output logic [$clog2(FIFO_DEPTH):0]        count_o,
  output logic                               overflow_o
);

  localparam int unsigned BW = $clog2(DATA_BITS_MAX + 1);

  logic                     write_q;
  logic                     push_req;
  logic                     pop;
  logic [DATA_BITS_MAX-1:0] fifo_dout;
  logic                     fifo_full;
  logic                     fifo_empty;

  tx_state_t                state;
  frame_cfg_t               cfg;
  logic [DATA_BITS_MAX-1:0] shreg;
  logic [DIVIDER_WIDTH-1:0] cnt;
  logic [3:0]               bit_idx;
  logic                     par_acc;
  logic [BW-1:0]            eff_bits;
  logic                     bit_done;
  logic                     frame_end;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS_MAX),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clock_i),
    .rst   (reset_i),
    .push  (push_req),
    .pop   (pop),
    .din   (data_i),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count_o)
  );

  always_comb begin
    eff_bits = data_bits_i;
    if (data_bits_i < BW'(5)) begin
      eff_bits = BW'(5);
    end else if (data_bits_i > BW'(DATA_BITS_MAX)) begin
      eff_bits = BW'(DATA_BITS_MAX);
    end
  end

  assign push_req  = write_i && !write_q;
  assign bit_done  = (cnt == '0);
  assign frame_end = bit_done &&
                     ((state == ST_STOP1 && !cfg.two_stop) || state == ST_STOP2);
  // Popping on the last stop cycle lets the next start bit follow immediately.
  assign pop       = !fifo_empty && (state == ST_IDLE || frame_end);

  assign full_o  = fifo_full;
  assign empty_o = fifo_empty;
  assign busy_o  = (state != ST_IDLE) || !fifo_empty;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      write_q    <= 1'b0;
      overflow_o <= 1'b0;
      state      <= ST_IDLE;
      serial_o   <= 1'b1;
      cfg        <= '0;
      shreg      <= '0;
      cnt        <= '0;
      bit_idx    <= '0;
      par_acc    <= 1'b0;
    end else begin
      write_q    <= write_i;
      overflow_o <= push_req && fifo_full && !pop;

      if (pop) begin
        state           <= ST_START;
        serial_o        <= 1'b0;
        shreg           <= fifo_dout;
        cfg.data_bits   <= 4'(eff_bits);
        cfg.parity_en   <= parity_bit_i;
        cfg.parity_even <= parity_even_i;
        cfg.two_stop    <= two_stop_bits_i;
        cfg.divider     <= DIVIDER_WIDTH_MAX'(clock_divider_i);
        cnt             <= clock_divider_i;
        bit_idx         <= '0;
        par_acc         <= 1'b0;
      end else if (state == ST_IDLE) begin
        serial_o <= 1'b1;
      end else if (!bit_done) begin
        cnt <= cnt - DIVIDER_WIDTH'(1);
      end else begin
        cnt <= DIVIDER_WIDTH'(cfg.divider);
        // Parity accumulates over exactly the bits shifted out, so masking is implicit.
        case (state)
          ST_START: begin
            state    <= ST_DATA;
            serial_o <= shreg[0];
            par_acc  <= par_acc ^ shreg[0];
            shreg    <= shreg >> 1;
          end
          ST_DATA: begin
            if (bit_idx == cfg.data_bits - 4'd1) begin
              if (cfg.parity_en) begin
                state    <= ST_PARITY;
                serial_o <= par_acc ^ ~cfg.parity_even;
              end else begin
                state    <= ST_STOP1;
                serial_o <= 1'b1;
              end
            end else begin
              bit_idx  <= bit_idx + 4'd1;
              serial_o <= shreg[0];
              par_acc  <= par_acc ^ shreg[0];
              shreg    <= shreg >> 1;
            end
          end
          ST_PARITY: begin
            state    <= ST_STOP1;
            serial_o <= 1'b1;
          end
          ST_STOP1: begin
            state    <= cfg.two_stop ? ST_STOP2 : ST_IDLE;
            serial_o <= 1'b1;
          end
          default: begin
            state    <= ST_IDLE;
            serial_o <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered: stimulus queues hand-computed frame
// bit patterns, a line monitor reconstructs frames and compares them.
module tb_uart_tx_buffered;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        write_i = 1'b0;
  logic [7:0]  data_i = '0;
  logic [3:0]  data_bits_i = 4'd8;
  logic        two_stop_bits_i = 1'b0;
  logic        parity_bit_i = 1'b0;
  logic        parity_even_i = 1'b0;
  logic [15:0] clock_divider_i = '0;
  logic        serial_o;
  logic        busy_o;
  logic        full_o;
  logic        empty_o;
  logic [4:0]  count_o;
  logic        overflow_o;

  int n_vec  = 0;
  int n_miss = 0;

  // bits[i] is the i-th line level of the frame, start bit first
  typedef struct {
    logic [15:0] bits;
    int unsigned len;
    int unsigned div;
    bit          contig;
    bit          abort;
  } exp_t;

  exp_t exq[$];

  uart_tx_buffered #(
    .DATA_BITS_MAX (8),
    .FIFO_DEPTH    (16),
    .DIVIDER_WIDTH (16)
  ) dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .write_i         (write_i),
    .data_i          (data_i),
    .data_bits_i     (data_bits_i),
    .two_stop_bits_i (two_stop_bits_i),
    .parity_bit_i    (parity_bit_i),
    .parity_even_i   (parity_even_i),
    .clock_divider_i (clock_divider_i),
    .serial_o        (serial_o),
    .busy_o          (busy_o),
    .full_o          (full_o),
    .empty_o         (empty_o),
    .count_o         (count_o),
    .overflow_o      (overflow_o)
  );

  always #5 clock_i = ~clock_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_miss++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  task automatic expect_frame(input logic [15:0] bits, input int unsigned len,
                              input bit contig, input bit abort);
    exp_t e;
    e.bits   = bits;
    e.len    = len;
    e.div    = int'(clock_divider_i);
    e.contig = contig;
    e.abort  = abort;
    exq.push_back(e);
  endtask

  function automatic logic [15:0] f8n1(input logic [7:0] d);
    return {6'b0, 1'b1, d, 1'b0};
  endfunction

  task automatic push(input logic [7:0] d);
    write_i = 1'b1;
    data_i  = d;
    tick();
    write_i = 1'b0;
    tick();
  endtask

  task automatic set_cfg(input logic [3:0] bits, input logic par, input logic even,
                         input logic two, input logic [15:0] div);
    data_bits_i     = bits;
    parity_bit_i    = par;
    parity_even_i   = even;
    two_stop_bits_i = two;
    clock_divider_i = div;
  endtask

  task automatic wait_idle(input int unsigned max, input string name);
    int unsigned i = 0;
    while ((exq.size() != 0 || busy_o !== 1'b0) && i < max) begin
      tick();
      i++;
    end
    n_vec++;
    if (i >= max) begin
      n_miss++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, max);
    end
  endtask

  task automatic wait_line_low(input int unsigned max, input string name);
    int unsigned i = 0;
    while (serial_o !== 1'b0 && i < max) begin
      tick();
      i++;
    end
    n_vec++;
    if (i >= max) begin
      n_miss++;
      $display("FAIL %s: no start bit within %0d cycles, required one", name, max);
    end
  endtask

  // Line monitor: frames are recognised by a falling edge on serial_o.
  initial begin : monitor
    int unsigned cyc;
    int unsigned last_end;
    int unsigned start;
    logic        prev;
    logic [15:0] got;
    bit          ok;
    bit          aborted;
    exp_t        e;
    cyc = 0;
    last_end = 0;
    prev = 1'b1;
    forever begin
      @(negedge clock_i);
      cyc++;
      if (!reset_i && prev === 1'b1 && serial_o === 1'b0) begin
        start = cyc;
        if (exq.size() == 0) begin
          n_vec++;
          n_miss++;
          $display("FAIL unexpected_frame: line fell at cycle %0d, required no frame", cyc);
          prev = 1'b0;
        end else begin
          e = exq[0];
          got = '0;
          ok = 1'b1;
          aborted = 1'b0;
          for (int unsigned b = 0; b < e.len && !aborted; b++) begin
            for (int unsigned c = 0; c <= e.div && !aborted; c++) begin
              if (b != 0 || c != 0) begin
                @(negedge clock_i);
                cyc++;
              end
              if (reset_i) begin
                aborted = 1'b1;
              end else begin
                if (c == 0) got[b] = serial_o;
                if (serial_o !== e.bits[b]) ok = 1'b0;
              end
            end
          end
          void'(exq.pop_front());
          n_vec++;
          if (e.abort) begin
            if (!aborted) begin
              n_miss++;
              $display("FAIL abort_frame: frame completed as %h, required reset abort", got);
            end
          end else if (aborted || !ok) begin
            n_miss++;
            $display("FAIL frame: line %h (aborted=%0d), required %h len %0d div %0d",
                     got, aborted, e.bits, e.len, e.div);
          end
          if (!e.abort && e.contig) begin
            n_vec++;
            if (start != last_end + 1) begin
              n_miss++;
              $display("FAIL contig: start at cycle %0d, required %0d", start, last_end + 1);
            end
          end
          last_end = cyc;
          prev = serial_o;
        end
      end else begin
        prev = serial_o;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    // Reset values
    tick();
    tick();
    check("rst_serial", serial_o, 1);
    check("rst_busy", busy_o, 0);
    check("rst_empty", empty_o, 1);
    check("rst_full", full_o, 0);
    check("rst_count", count_o, 0);
    check("rst_overflow", overflow_o, 0);
    reset_i = 1'b0;
    tick();

    // 8N1 divider 1, 0x55: start latency and busy fall
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 16'd1);
    expect_frame(16'h02AA, 10, 1'b0, 1'b0);
    write_i = 1'b1;
    data_i  = 8'h55;
    tick();
    check("push_busy", busy_o, 1);
    check("push_count", count_o, 1);
    check("push_empty", empty_o, 0);
    check("push_serial_hi", serial_o, 1);
    tick();
    check("start_serial_lo", serial_o, 0);
    check("start_count", count_o, 0);
    data_i = 8'h77;
    repeat (19) tick();
    check("stop_busy", busy_o, 1);
    check("stop_serial", serial_o, 1);
    tick();
    check("busy_fall", busy_o, 0);

    // Held write must not re-push; a fresh edge pushes 0xAA once
    repeat (10) tick();
    check("hold_count", count_o, 0);
    check("hold_busy", busy_o, 0);
    write_i = 1'b0;
    tick();
    expect_frame(16'h0354, 10, 1'b0, 1'b0);
    write_i = 1'b1;
    data_i  = 8'hAA;
    tick();
    write_i = 1'b0;
    wait_idle(200, "idle_aa");

    // 7E2 divider 0, three back-to-back frames
    set_cfg(4'd7, 1'b1, 1'b1, 1'b1, 16'd0);
    expect_frame(16'h0606, 11, 1'b0, 1'b0);
    expect_frame(16'h0682, 11, 1'b1, 1'b0);
    expect_frame(16'h07EA, 11, 1'b1, 1'b0);
    push(8'h03);
    push(8'h41);
    push(8'hF5);
    wait_idle(200, "idle_7e2");

    // 5O1 divider 2, all ones
    set_cfg(4'd5, 1'b1, 1'b0, 1'b0, 16'd2);
    expect_frame(16'h00BE, 8, 1'b0, 1'b0);
    push(8'hFF);
    wait_idle(200, "idle_5o1");

    // Data length below 5 acts as 5
    set_cfg(4'd2, 1'b0, 1'b0, 1'b0, 16'd0);
    expect_frame(16'h0074, 7, 1'b0, 1'b0);
    push(8'h3A);
    wait_idle(200, "idle_len2");

    // Data length above the maximum acts as 8
    set_cfg(4'd15, 1'b0, 1'b0, 1'b0, 16'd0);
    expect_frame(f8n1(8'h81), 10, 1'b0, 1'b0);
    push(8'h81);
    wait_idle(200, "idle_len15");

    // Fill the queue during a frame, then overflow with a 17th word
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 16'd7);
    expect_frame(f8n1(8'h01), 10, 1'b0, 1'b0);
    push(8'h01);
    wait_line_low(50, "fill_start");
    for (int unsigned i = 0; i < 16; i++) begin
      expect_frame(f8n1(8'(8'h10 + i)), 10, 1'b1, 1'b0);
      push(8'(8'h10 + i));
    end
    check("fill_full", full_o, 1);
    check("fill_count", count_o, 16);
    check("fill_no_ovf", overflow_o, 0);
    write_i = 1'b1;
    data_i  = 8'hEE;
    tick();
    check("ovf_pulse", overflow_o, 1);
    check("ovf_count", count_o, 16);
    check("ovf_full", full_o, 1);
    write_i = 1'b0;
    tick();
    check("ovf_clear", overflow_o, 0);
    wait_idle(17 * 80 + 200, "idle_fill");

    // Reset in the middle of the data bits
    set_cfg(4'd8, 1'b0, 1'b0, 1'b0, 16'd3);
    expect_frame(16'h0000, 10, 1'b0, 1'b1);
    push(8'h00);
    push(8'h5A);
    check("pre_rst_count", count_o, 1);
    wait_line_low(50, "rst_start");
    repeat (6) tick();
    reset_i = 1'b1;
    tick();
    check("midrst_serial", serial_o, 1);
    check("midrst_count", count_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_empty", empty_o, 1);
    reset_i = 1'b0;
    repeat (60) tick();
    check("post_rst_busy", busy_o, 0);
    check("post_rst_serial", serial_o, 1);
    check("queue_drained", exq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
